insn_cache: RTL and testbench
=============================

# insn_cache

Direct-mapped, read-only instruction cache between the core's fetch stage and the instruction port of the bus master. It serves 32-bit instruction words to the core and, on a miss, issues one 128-bit line read through the bus master's `insn_start`/`insn_ready` handshake. It is not used in Verilator builds, where the bus master's instruction port is 32 bits wide.

## Interface
- `LINES`, default 16: number of cache lines; a power of two, 2 to 256. `IDX = $clog2(LINES)`, `TAG = 28 - IDX`.
- `clk`  in  1: the only clock.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `core_valid`  in  1: fetch request. Held with `core_addr` stable until `core_ready`.
- `core_addr`  in  30: word address of the requested instruction.
- `core_ready`  out  1: one-cycle pulse; `core_insn` is valid in that cycle.
- `core_insn`  out  32: instruction word.
- `flush`  in  1: invalidates all lines.
- `insn_start`  out  1: one-cycle line-read request to the bus master.
- `insn_addr`  out  28: line address, equal to `core_addr[29:2]`.
- `insn_ready`  in  1: line data is valid this cycle.
- `insn_data_rd`  in  128: line data. Word `w` is `insn_data_rd[32*w +: 32]`.

## Operation
- The request address splits as follows:
  - `off = core_addr[1:0]`
  - `idx = core_addr[IDX+1:2]`
  - `tag = core_addr[29:IDX+2]`
- Per-line storage: `valid` bit, `TAG`-bit tag, 128-bit data.
- FSM states: IDLE, LOOKUP, FILL. Transitions:
  - IDLE: if `core_valid`, latch `core_addr` into `req_addr` and go to LOOKUP.
  - LOOKUP, hit (`valid[idx]` set and tag matches): `core_ready`=1, `core_insn` = stored word `off`, go to IDLE.
  - LOOKUP, miss: register `insn_start`=1 and `insn_addr=req_addr[29:2]`, go to FILL.
  - FILL: wait for `insn_ready`. In that cycle:
    - write data and tag, and set `valid` unless a flush is pending;
    - `core_ready`=1, `core_insn = insn_data_rd[32*off +: 32]`;
    - go to IDLE.
- Flush behaviour:
  - In IDLE or LOOKUP, `flush` clears every `valid` bit in one cycle.
  - A LOOKUP coinciding with `flush` evaluates the pre-flush valid bits.
  - In FILL, `flush` clears all valid bits and sets `flush_pend`. The in-flight fill still answers the core but leaves its line invalid. `flush_pend` clears on leaving FILL.
  - `flush` in the same cycle as `insn_ready`: the line is not marked valid.
- A fill replaces the indexed line unconditionally.
- `insn_addr` holds its last value while idle.

## Timing
- Reset values:
  - `core_ready`=0, `insn_start`=0, `insn_addr`=0, `core_insn`=0.
  - All valid bits 0, FSM in IDLE, `flush_pend`=0.
- Hit latency: `core_ready` 2 cycles after `core_valid` is first sampled (IDLE→LOOKUP→respond). Back-to-back hits give one instruction every 2 cycles.
- Miss path:
  - `insn_start` is high exactly in the cycle after LOOKUP.
  - `core_ready` coincides with `insn_ready`, at earliest 2 cycles after `insn_start`.
- `insn_start` is never reasserted while in FILL. At most one outstanding bus read.
- `core_ready` and `core_insn` are combinational from the state, tag compare, and `insn_data_rd`. All other outputs are registered.
- Reset mid-FILL aborts the fill: no line is written and no `core_ready` is produced. The bus master shares `rst_n`, so no response arrives afterwards.
- `core_valid` dropping before `core_ready` is a protocol violation. Behaviour is then unspecified, except that the fill still completes.

## Structure
- `cache_pkg`: `LINE_BITS`=128, `WORD_BITS`=32, `LINE_ADDR_BITS`=28, the FSM state enum, and a `word_sel(line, off)` function.
- Sub-module `insn_cache_store`:
  - Valid array, tag array and data array.
  - One read port (combinational by index) and one write port.
  - Synchronous single-cycle flush-all of the valid bits.
- Top level holds the FSM, `req_addr`, `flush_pend` and the bus outputs.

## Test plan
- Cold miss, `LINES`=16: request `core_addr`=0x00000041. Expect `insn_start` with `insn_addr`=0x0000010. Bus returns `insn_data_rd`=0x44444444_33333333_22222222_11111111 after 3 cycles. Expect `core_ready` in the `insn_ready` cycle with `core_insn`=0x22222222.
- Hit after fill: request 0x00000043. Expect `core_ready` 2 cycles after the request, `core_insn`=0x44444444, and no `insn_start`.
- Conflict: request 0x00000441 (same idx 0, different tag). Expect a miss and a refill. A subsequent 0x00000041 misses again.
- Flush in IDLE after the fill, then request 0x00000040. Expect a miss.
- Flush during FILL, including a flush in the same cycle as `insn_ready`. Expect the core still gets the correct word and a repeat request misses.
- Assert `rst_n`=0 one cycle after `insn_start`, then release. Expect all outputs at reset values, no `core_ready`, and the next request misses.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared widths, FSM encoding and word-select helper for the instruction cache.
package cache_pkg;

  localparam int unsigned LINE_BITS      = 128;
  localparam int unsigned WORD_BITS      = 32;
  localparam int unsigned LINE_ADDR_BITS = 28;
  localparam int unsigned WORD_ADDR_BITS = 30;
  localparam int unsigned OFF_BITS       = 2;
  localparam int unsigned LINE_WORDS     = LINE_BITS / WORD_BITS;

  typedef logic [LINE_BITS-1:0]      line_t;
  typedef logic [WORD_BITS-1:0]      word_t;
  typedef logic [LINE_ADDR_BITS-1:0] line_addr_t;
  typedef logic [WORD_ADDR_BITS-1:0] word_addr_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_FILL   = 2'd2
  } state_e;

  // Pick word 'off' out of a 128-bit line (word 0 in the low bits).
  function automatic word_t word_sel(input line_t line, input logic [OFF_BITS-1:0] off);
    logic [LINE_WORDS-1:0][WORD_BITS-1:0] words;
    words = line;
    return words[off];
  endfunction

endpackage

// File: rtl/insn_cache_if.sv
// Fetch-side and bus-master-side signals of the instruction cache.
interface insn_cache_if;
  import cache_pkg::*;

  logic       core_valid;
  word_addr_t core_addr;
  logic       core_ready;
  word_t      core_insn;
  logic       flush;
  logic       insn_start;
  line_addr_t insn_addr;
  logic       insn_ready;
  line_t      insn_data_rd;

  // Cache side: answers the core, requests lines from the bus master.
  modport slave (
    input  core_valid, core_addr, flush, insn_ready, insn_data_rd,
    output core_ready, core_insn, insn_start, insn_addr
  );

  // Environment side: the fetch stage plus the bus master.
  modport master (
    output core_valid, core_addr, flush, insn_ready, insn_data_rd,
    input  core_ready, core_insn, insn_start, insn_addr
  );

endinterface

// File: rtl/insn_cache_store.sv
// Valid/tag/data arrays: combinational read by index, one write port, flush-all of valid bits.
module insn_cache_store
  import cache_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned IDX   = $clog2(LINES),
  parameter int unsigned TAG   = LINE_ADDR_BITS - IDX
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush_i,
  input  logic [IDX-1:0] rd_idx_i,
  output logic           rd_valid_c_o,
  output logic [TAG-1:0] rd_tag_c_o,
  output line_t          rd_data_c_o,
  input  logic           wr_en_i,
  input  logic [IDX-1:0] wr_idx_i,
  input  logic [TAG-1:0] wr_tag_i,
  input  line_t          wr_data_i,
  input  logic           wr_valid_i
);

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG-1:0]   tag_q  [LINES];
  line_t            data_q [LINES];

  // Valid update: a flush wins over the write, clearing every line.
  always_comb begin
    valid_d = valid_q;
    if (wr_en_i) valid_d[wr_idx_i] = wr_valid_i;
    if (flush_i) valid_d = '0;
  end

  // Valid bits are the only state that needs a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Tag and data are overwritten on every fill, valid or not.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_c_o = valid_q[rd_idx_i];
  assign rd_tag_c_o   = tag_q[rd_idx_i];
  assign rd_data_c_o  = data_q[rd_idx_i];

endmodule

// File: rtl/insn_cache.sv
// Direct-mapped read-only instruction cache: FSM, request latch and bus-side registers.
module insn_cache
  import cache_pkg::*;
#(
  parameter int unsigned LINES = 16
) (
  input logic          clk,
  input logic          rst_n,
  insn_cache_if.slave  bus
);

  localparam int unsigned IDX = $clog2(LINES);
  localparam int unsigned TAG = LINE_ADDR_BITS - IDX;

  state_e     state_q, state_d;
  word_addr_t req_addr_q, req_addr_d;
  logic       flush_pend_q, flush_pend_d;
  logic       insn_start_q, insn_start_d;
  line_addr_t insn_addr_q, insn_addr_d;

  logic [OFF_BITS-1:0] req_off;
  logic [IDX-1:0]      req_idx;
  logic [TAG-1:0]      req_tag;

  logic           rd_valid;
  logic [TAG-1:0] rd_tag;
  line_t          rd_data;
  logic           hit;
  logic           wr_en;
  logic           wr_valid;
  logic           core_ready_c;
  word_t          core_insn_c;

  assign req_off = req_addr_q[OFF_BITS-1:0];
  assign req_idx = req_addr_q[IDX+OFF_BITS-1:OFF_BITS];
  assign req_tag = req_addr_q[WORD_ADDR_BITS-1:IDX+OFF_BITS];

  // Lookup reads pre-flush valid bits because the flush lands on the next edge.
  assign hit      = rd_valid && (rd_tag == req_tag);
  assign wr_valid = ~(flush_pend_q | bus.flush);

  insn_cache_store #(
    .LINES (LINES),
    .IDX   (IDX),
    .TAG   (TAG)
  ) u_store (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (bus.flush),
    .rd_idx_i     (req_idx),
    .rd_valid_c_o (rd_valid),
    .rd_tag_c_o   (rd_tag),
    .rd_data_c_o  (rd_data),
    .wr_en_i      (wr_en),
    .wr_idx_i     (req_idx),
    .wr_tag_i     (req_tag),
    .wr_data_i    (bus.insn_data_rd),
    .wr_valid_i   (wr_valid)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (bus.core_valid) state_d = ST_LOOKUP;
      ST_LOOKUP: state_d = hit ? ST_IDLE : ST_FILL;
      ST_FILL:   if (bus.insn_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: core response, store write, and next values of the registered bus side.
  always_comb begin
    req_addr_d   = req_addr_q;
    insn_start_d = 1'b0;
    insn_addr_d  = insn_addr_q;
    flush_pend_d = 1'b0;
    core_ready_c = 1'b0;
    core_insn_c  = '0;
    wr_en        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.core_valid) req_addr_d = bus.core_addr;
      end
      ST_LOOKUP: begin
        if (hit) begin
          core_ready_c = 1'b1;
          core_insn_c  = word_sel(rd_data, req_off);
        end else begin
          insn_start_d = 1'b1;
          insn_addr_d  = req_addr_q[WORD_ADDR_BITS-1:OFF_BITS];
        end
      end
      ST_FILL: begin
        if (bus.insn_ready) begin
          wr_en        = 1'b1;
          core_ready_c = 1'b1;
          core_insn_c  = word_sel(bus.insn_data_rd, req_off);
        end else begin
          flush_pend_d = flush_pend_q | bus.flush;
        end
      end
      default: ;
    endcase
  end

  // Request latch, pending-flush flag and registered bus request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_addr_q   <= '0;
      flush_pend_q <= 1'b0;
      insn_start_q <= 1'b0;
      insn_addr_q  <= '0;
    end else begin
      req_addr_q   <= req_addr_d;
      flush_pend_q <= flush_pend_d;
      insn_start_q <= insn_start_d;
      insn_addr_q  <= insn_addr_d;
    end
  end

  assign bus.core_ready = core_ready_c;
  assign bus.core_insn  = core_insn_c;
  assign bus.insn_start = insn_start_q;
  assign bus.insn_addr  = insn_addr_q;

endmodule

// File: tb/tb_insn_cache.sv
// Self-checking bench for insn_cache with a line-granular reference model.
module tb_insn_cache;

  localparam int LINES = 16;
  localparam int IDX   = 4;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  insn_cache_if bus_if ();

  insn_cache #(.LINES(LINES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what each cache line holds.
  bit           m_valid [LINES];
  int unsigned  m_tag   [LINES];
  logic [127:0] m_data  [LINES];
  logic [127:0] next_line;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  // One complete fetch. dly = cycles from insn_start to insn_ready (>= 2).
  // flush_at = cycle index (0 = request cycle) in which flush is pulsed, -1 for none.
  task automatic fetch(input logic [29:0] addr, input int dly, input int flush_at);
    int unsigned  idx, tag, off;
    bit           hit, fill_flushed;
    logic [127:0] line;
    idx = (32'(addr) >> 2) % LINES;
    tag = 32'(addr) >> (2 + IDX);
    off = 32'(addr) % 4;

    @(posedge clk); #1;
    bus_if.core_valid = 1'b1;
    bus_if.core_addr  = addr;
    bus_if.flush      = (flush_at == 0);
    @(negedge clk);
    chk("req_cycle_ready", 32'(bus_if.core_ready), 32'd0);
    if (flush_at == 0) model_clear();
    hit = m_valid[idx] && (m_tag[idx] == tag);

    @(posedge clk); #1;
    bus_if.flush = (flush_at == 1);
    @(negedge clk);
    chk("lookup_ready", 32'(bus_if.core_ready), 32'(hit));
    if (hit) chk("hit_insn", bus_if.core_insn, m_data[idx][off*32 +: 32]);
    if (flush_at == 1) model_clear();

    if (!hit) begin
      line = next_line;
      next_line = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      bus_if.flush = (flush_at == 2);
      @(negedge clk);
      chk("start_pulse", 32'(bus_if.insn_start), 32'd1);
      chk("start_addr", 32'(bus_if.insn_addr), 32'(addr) >> 2);
      chk("start_ready", 32'(bus_if.core_ready), 32'd0);
      for (int c = 3; c <= 2 + dly; c++) begin
        @(posedge clk); #1;
        bus_if.flush = (flush_at == c);
        if (c == 2 + dly) begin
          bus_if.insn_ready   = 1'b1;
          bus_if.insn_data_rd = line;
        end
        @(negedge clk);
        chk("fill_start_low", 32'(bus_if.insn_start), 32'd0);
        chk("fill_ready", 32'(bus_if.core_ready), 32'(c == 2 + dly));
      end
      chk("fill_insn", bus_if.core_insn, line[off*32 +: 32]);
      chk("addr_hold", 32'(bus_if.insn_addr), 32'(addr) >> 2);
      fill_flushed = (flush_at >= 2) && (flush_at <= 2 + dly);
      if (fill_flushed) model_clear();
      m_tag[idx]   = tag;
      m_data[idx]  = line;
      m_valid[idx] = !fill_flushed;
    end

    @(posedge clk); #1;
    bus_if.core_valid   = 1'b0;
    bus_if.flush        = 1'b0;
    bus_if.insn_ready   = 1'b0;
    bus_if.insn_data_rd = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    chk("after_start", 32'(bus_if.insn_start), 32'd0);
    chk("after_ready", 32'(bus_if.core_ready), 32'd0);
  endtask

  task automatic flush_idle();
    @(posedge clk); #1;
    bus_if.flush = 1'b1;
    @(posedge clk); #1;
    bus_if.flush = 1'b0;
    model_clear();
  endtask

  // Miss, then pull reset one cycle after insn_start.
  task automatic reset_mid_fill(input logic [29:0] addr);
    @(posedge clk); #1;
    bus_if.core_valid = 1'b1;
    bus_if.core_addr  = addr;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_lookup_miss", 32'(bus_if.core_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_start", 32'(bus_if.insn_start), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus_if.core_valid = 1'b0;
    @(negedge clk);
    chk("rst_core_ready", 32'(bus_if.core_ready), 32'd0);
    chk("rst_insn_start", 32'(bus_if.insn_start), 32'd0);
    chk("rst_insn_addr", 32'(bus_if.insn_addr), 32'd0);
    chk("rst_core_insn", bus_if.core_insn, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus_if.core_ready), 32'd0);
    chk("post_rst_start", 32'(bus_if.insn_start), 32'd0);
    model_clear();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [29:0] a;
    int          f;
    rst_n               = 1'b0;
    bus_if.core_valid   = 1'b0;
    bus_if.core_addr    = '0;
    bus_if.flush        = 1'b0;
    bus_if.insn_ready   = 1'b0;
    bus_if.insn_data_rd = '0;
    model_clear();
    for (int i = 0; i < LINES; i++) begin
      m_tag[i]  = 0;
      m_data[i] = '0;
    end

    @(negedge clk);
    chk("reset_core_ready", 32'(bus_if.core_ready), 32'd0);
    chk("reset_insn_start", 32'(bus_if.insn_start), 32'd0);
    chk("reset_insn_addr", 32'(bus_if.insn_addr), 32'd0);
    chk("reset_core_insn", bus_if.core_insn, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Cold miss, then hit on the same line.
    next_line = 128'h44444444_33333333_22222222_11111111;
    fetch(30'h41, 3, -1);
    chk("plan_cold_word", bus_if.core_insn, 32'd0);
    fetch(30'h43, 2, -1);

    // Conflict on index 0, then the original line misses again.
    fetch(30'h441, 2, -1);
    fetch(30'h41, 4, -1);
    fetch(30'h41, 2, -1);

    // Flush while idle.
    flush_idle();
    fetch(30'h40, 3, -1);
    fetch(30'h42, 2, -1);

    // Flush in the middle of a fill, then the line refills and sticks.
    fetch(30'h100, 4, 3);
    fetch(30'h101, 2, -1);
    fetch(30'h102, 2, -1);

    // Flush in the same cycle as insn_ready.
    fetch(30'h200, 3, 5);
    fetch(30'h203, 2, -1);

    // Flush on the insn_start cycle, and flush during a hit's lookup.
    fetch(30'h304, 2, 2);
    fetch(30'h304, 2, -1);
    fetch(30'h305, 2, 1);
    fetch(30'h306, 2, -1);

    // Flush in the request cycle turns a would-be hit into a miss.
    fetch(30'h306, 2, 0);

    // Reset one cycle after insn_start.
    reset_mid_fill(30'h41);
    fetch(30'h41, 2, -1);

    // Random traffic over a small address pool so hits, conflicts and flushes mix.
    for (int n = 0; n < 200; n++) begin
      a = 30'(($urandom_range(0, 2) << (2 + IDX)) | $urandom_range(0, 4 * LINES - 1));
      f = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1;
      fetch(a, int'($urandom_range(2, 5)), f);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
